sipo_deser: RTL and testbench
=============================

# sipo_deser

Serial-in, parallel-out deserializer: the receive end of the 4-bit parallel register link. It collects framed serial bits, one per `s_valid` cycle, into a `WIDTH`-bit word. It then presents the word on a valid/ready parallel output, with overrun and framing-error reporting. It sits between a serial line and any parallel-load register stage.

## Interface
- `WIDTH`, 4, word length in bits; legal range 2 to 32.
- `MSB_FIRST`, 1, bit order: 1 = first bit received lands in `p_out[WIDTH-1]`; 0 = first bit lands in `p_out[0]`.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `s_in`  input  1  serial data bit.
- `s_valid`  input  1  `s_in` is sampled this cycle.
- `s_start`  input  1  qualified by `s_valid`: this bit is the first bit of a word.
- `p_out`  output  WIDTH  assembled word (holding register).
- `p_valid`  output  1  `p_out` holds an unconsumed word.
- `p_ready`  input  1  downstream accepts `p_out` when `p_valid && p_ready`.
- `overrun`  output  1  sticky: a completed word was dropped.
- `clr_ovr`  input  1  synchronous clear of `overrun`.
- `frame_err`  output  1  one-cycle pulse: a partial word was abandoned.

## Operation
- State machine (`IDLE`, `SHIFT`), plus a shift register and a bit counter `cnt` of width clog2(WIDTH+1).
- IDLE:
  - `s_valid && s_start` captures `s_in` as bit 0 of the frame, sets `cnt=1`, and goes to SHIFT.
  - `s_valid` without `s_start` is ignored.
- SHIFT with `s_valid && !s_start`:
  - Shift `s_in` in and increment `cnt`.
  - When this is bit WIDTH-1, the word is complete; go to IDLE with `cnt=0`.
- SHIFT with `s_valid && s_start`:
  - Pulse `frame_err` for one cycle and discard the partial word.
  - Capture the new bit as bit 0 with `cnt=1`; stay in SHIFT.
- SHIFT with `s_valid` low: hold all state. Arbitrary gaps between bits are legal.
- Word completion:
  - If the holding register is empty (`!p_valid`), or drains the same cycle (`p_valid && p_ready`), load it and set `p_valid=1`.
  - Otherwise drop the new word, leave `p_out`/`p_valid` unchanged, and set `overrun=1`.
- Bit order:
  - `MSB_FIRST=1`: shift left, inserting into the LSB.
  - `MSB_FIRST=0`: shift right, inserting into the MSB.
- `p_valid && p_ready` with no word completing clears `p_valid`. `p_out` retains its value.
- `overrun` priority: if `clr_ovr` and a new overrun occur in the same cycle, the set wins.
- Reset during a partial word discards it; no `frame_err` pulse.

## Timing
- Reset values: `p_out=0`, `p_valid=0`, `overrun=0`, `frame_err=0`, state IDLE, `cnt=0`, shift register 0.
- Latency:
  - The rising edge that samples the final bit also loads `p_out` and sets `p_valid`.
  - `p_valid` is therefore high in the cycle immediately after the last `s_valid` cycle.
  - Minimum word period is WIDTH cycles; back-to-back frames are sustained with `p_ready` held high.
- Handshake:
  - `p_out` is stable while `p_valid && !p_ready`.
  - `p_valid` never deasserts without a transfer (except on reset).
- Registering and input constraints:
  - `frame_err` is registered and high for exactly one cycle after the offending edge.
  - All outputs come directly from flops.
  - The serial side has no backpressure.

## Structure
- Shared package `sipo_pkg` holds:
  - the `sipo_state_t` enum (`IDLE`, `SHIFT`);
  - a `SIPO_MAX_WIDTH = 32` constant for parameter checking.
- One sub-module, `sipo_hold_reg`: the WIDTH-bit output holding register with `p_valid`/`p_ready` and the load/overrun decision.
- Top level contains the FSM, counter and shift register.
- Elaboration-time check: WIDTH must lie in 2 to `SIPO_MAX_WIDTH`.

## Test plan
- Basic, MSB-first (WIDTH=4, MSB_FIRST=1, `p_ready=1`): bits 1,0,1,1 with `s_start` on the first bit -> `p_out=4'hB`, `p_valid` high one cycle after bit 4.
- Basic, LSB-first: MSB_FIRST=0, same bits -> `p_out=4'hD`.
- Gapped input: 3 idle cycles between each bit of 0,1,1,0 (MSB-first) -> `p_out=4'h6`, `p_valid` rises only after the 4th bit.
- Backpressure and overrun:
  - Hold `p_ready=0`; send 4'hA then 4'h5 -> `p_out` stays 4'hA, `overrun=1`.
  - `clr_ovr` -> `overrun=0`.
  - Raise `p_ready` in the cycle a third word 4'h3 completes -> `p_out=4'h3`, `p_valid` stays 1, no overrun.
- Resync: `s_start` on the 3rd bit of a frame, followed by 1,1,1,1 -> `frame_err` pulses one cycle, then `p_out=4'hF`.
- Reset mid-operation: deassert `rst_n` after 2 bits, then send a full frame 1,0,0,1 -> all outputs 0 during reset, then `p_out=4'h9`, no `frame_err`.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and limits for the serial-in, parallel-out deserializer.
package sipo_pkg;

    localparam int SIPO_MAX_WIDTH = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sipo_state_t;

endpackage

// File: rtl/sipo_hold_reg.sv
// Output holding register: accepts completed words, runs the valid/ready
// handshake and flags words dropped while the register is still occupied.
module sipo_hold_reg
    import sipo_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] word_in,
    input  logic             load_req,
    input  logic             p_ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] p_out_r;
    logic [WIDTH-1:0] p_out_nxt_s;
    logic             p_valid_r;
    logic             p_valid_nxt_s;
    logic             overrun_r;
    logic             overrun_nxt_s;
    logic             accept_s;

    // Load/drain/overrun decision; a draining register can take a new word the same cycle.
    always_comb begin
        p_out_nxt_s   = p_out_r;
        p_valid_nxt_s = p_valid_r;
        overrun_nxt_s = overrun_r;
        accept_s      = !p_valid_r || p_ready;
        if (load_req && accept_s) begin
            p_out_nxt_s   = word_in;
            p_valid_nxt_s = 1'b1;
        end else if (p_valid_r && p_ready) begin
            p_valid_nxt_s = 1'b0;
        end else begin
            p_valid_nxt_s = p_valid_r;
        end
        // A new drop outranks a clear arriving in the same cycle.
        if (load_req && !accept_s) begin
            overrun_nxt_s = 1'b1;
        end else if (clr_ovr) begin
            overrun_nxt_s = 1'b0;
        end else begin
            overrun_nxt_s = overrun_r;
        end
    end

    // Holding register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_out_r   <= {WIDTH{1'b0}};
            p_valid_r <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            p_out_r   <= p_out_nxt_s;
            p_valid_r <= p_valid_nxt_s;
            overrun_r <= overrun_nxt_s;
        end
    end

    assign p_out   = p_out_r;
    assign p_valid = p_valid_r;
    assign overrun = overrun_r;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserializer: frames s_in bits into WIDTH-bit words
// and hands them to a valid/ready holding register.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_in,
    input  logic             s_valid,
    input  logic             s_start,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             overrun,
    input  logic             clr_ovr,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    generate
        if (WIDTH < 2 || WIDTH > SIPO_MAX_WIDTH) begin : g_bad_width
            $error("sipo_deser: WIDTH must lie in 2..SIPO_MAX_WIDTH");
        end
    endgenerate

    sipo_state_t      state_r;
    sipo_state_t      state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_nxt_s;
    logic             frame_err_r;
    logic             frame_err_nxt_s;
    logic             word_done_s;
    logic [WIDTH-1:0] shifted_s;
    logic [WIDTH-1:0] first_s;

    // First bit ends up at the MSB (left shift) or at the LSB (right shift).
    assign shifted_s = (MSB_FIRST != 0) ? {shift_r[WIDTH-2:0], s_in}
                                        : {s_in, shift_r[WIDTH-1:1]};
    assign first_s   = (MSB_FIRST != 0) ? {{(WIDTH-1){1'b0}}, s_in}
                                        : {s_in, {(WIDTH-1){1'b0}}};

    // Framing FSM, bit counter and shift register next state.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        shift_nxt_s     = shift_r;
        frame_err_nxt_s = 1'b0;
        word_done_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (s_valid && s_start) begin
                    shift_nxt_s = first_s;
                    cnt_nxt_s   = CNT_W'(1);
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (s_valid && s_start) begin
                    frame_err_nxt_s = 1'b1;
                    shift_nxt_s     = first_s;
                    cnt_nxt_s       = CNT_W'(1);
                end else if (s_valid) begin
                    shift_nxt_s = shifted_s;
                    if (cnt_r == CNT_W'(WIDTH - 1)) begin
                        word_done_s = 1'b1;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        state_nxt_s = IDLE;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Framing state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            shift_r     <= {WIDTH{1'b0}};
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            shift_r     <= shift_nxt_s;
            frame_err_r <= frame_err_nxt_s;
        end
    end

    assign frame_err = frame_err_r;

    sipo_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .word_in  (shifted_s),
        .load_req (word_done_s),
        .p_ready  (p_ready),
        .clr_ovr  (clr_ovr),
        .p_out    (p_out),
        .p_valid  (p_valid),
        .overrun  (overrun)
    );

endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench for sipo_deser: an MSB-first and an LSB-first instance share
// the same serial stimulus; expected words are queued as frames are sent.
module tb_sipo_deser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, s_in, s_valid, s_start, p_ready, clr_ovr;
    logic [3:0] p_out_m, p_out_l;
    logic       pv_m, pv_l, ovr_m, ovr_l, fe_m, fe_l;

    int checks   = 0;
    int failures = 0;
    int fe_cnt_m = 0;
    int fe_cnt_l = 0;
    logic [3:0] q_m[$];
    logic [3:0] q_l[$];

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .s_in(s_in), .s_valid(s_valid), .s_start(s_start),
        .p_out(p_out_m), .p_valid(pv_m), .p_ready(p_ready), .overrun(ovr_m),
        .clr_ovr(clr_ovr), .frame_err(fe_m)
    );

    sipo_deser #(.WIDTH(4), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .s_in(s_in), .s_valid(s_valid), .s_start(s_start),
        .p_out(p_out_l), .p_valid(pv_l), .p_ready(p_ready), .overrun(ovr_l),
        .clr_ovr(clr_ovr), .frame_err(fe_l)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] rev4(input logic [3:0] v);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = v[3-i];
        return r;
    endfunction

    // Scoreboard: a word leaves the DUT on every cycle with p_valid && p_ready.
    always @(negedge clk) begin
        if (fe_m) fe_cnt_m++;
        if (fe_l) fe_cnt_l++;
        if (pv_m && p_ready) begin
            if (q_m.size() == 0) chk("sb_msb_unexpected", 32'd1, 32'd0);
            else chk("sb_msb", {28'd0, p_out_m}, {28'd0, q_m.pop_front()});
        end
        if (pv_l && p_ready) begin
            if (q_l.size() == 0) chk("sb_lsb_unexpected", 32'd1, 32'd0);
            else chk("sb_lsb", {28'd0, p_out_l}, {28'd0, q_l.pop_front()});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input logic st);
        s_in    = b;
        s_valid = 1'b1;
        s_start = st;
        step();
        s_valid = 1'b0;
        s_start = 1'b0;
        s_in    = 1'b0;
    endtask

    // v[3] is the first bit on the line.
    task automatic send_frame(input logic [3:0] v, input bit push, input int gap,
                              input bit ready_last, input bit clr_last);
        for (int i = 3; i >= 0; i--) begin
            if (i == 0) begin
                if (ready_last) p_ready = 1'b1;
                if (clr_last) clr_ovr = 1'b1;
                if (push) begin
                    q_m.push_back(v);
                    q_l.push_back(rev4(v));
                end
            end
            drive_bit(v[i], i == 3);
            clr_ovr = 1'b0;
            if (i != 0) repeat (gap) step();
        end
    endtask

    initial begin
        rst_n = 1'b0; s_in = 1'b0; s_valid = 1'b0; s_start = 1'b0;
        p_ready = 1'b1; clr_ovr = 1'b0;
        step(); step();
        chk("rst_pout", {28'd0, p_out_m}, 32'd0);
        chk("rst_pvalid", {31'd0, pv_m | pv_l}, 32'd0);
        chk("rst_ovr", {31'd0, ovr_m | ovr_l}, 32'd0);
        chk("rst_ferr", {31'd0, fe_m | fe_l}, 32'd0);
        rst_n = 1'b1;
        step();

        // Stray bit without s_start in IDLE is ignored.
        drive_bit(1'b1, 1'b0);
        step();
        chk("stray_pvalid", {31'd0, pv_m}, 32'd0);

        // Basic frame 1,0,1,1.
        send_frame(4'hB, 1'b1, 0, 1'b0, 1'b0);
        chk("basic_pvalid", {31'd0, pv_m}, 32'd1);
        chk("basic_msb", {28'd0, p_out_m}, 32'hB);
        chk("basic_lsb", {28'd0, p_out_l}, 32'hD);
        step();
        chk("basic_drained", {31'd0, pv_m}, 32'd0);
        chk("basic_hold", {28'd0, p_out_m}, 32'hB);

        // Gapped frame 0,1,1,0 with 3 idle cycles between bits.
        q_m.push_back(4'h6);
        q_l.push_back(4'h6);
        drive_bit(1'b0, 1'b1); repeat (3) step();
        drive_bit(1'b1, 1'b0); repeat (3) step();
        drive_bit(1'b1, 1'b0); repeat (3) step();
        chk("gap_early_pvalid", {31'd0, pv_m}, 32'd0);
        drive_bit(1'b0, 1'b0);
        chk("gap_pvalid", {31'd0, pv_m}, 32'd1);
        chk("gap_pout", {28'd0, p_out_m}, 32'h6);
        step();

        // Back-to-back frames at full rate.
        send_frame(4'hC, 1'b1, 0, 1'b0, 1'b0);
        send_frame(4'h7, 1'b1, 0, 1'b0, 1'b0);
        chk("b2b_pvalid", {31'd0, pv_m}, 32'd1);
        chk("b2b_lsb", {28'd0, p_out_l}, 32'hE);
        step();

        // Backpressure and overrun.
        p_ready = 1'b0;
        send_frame(4'hA, 1'b1, 0, 1'b0, 1'b0);
        send_frame(4'h5, 1'b0, 0, 1'b0, 1'b0);
        chk("ovr_set", {31'd0, ovr_m & ovr_l}, 32'd1);
        chk("ovr_hold_msb", {28'd0, p_out_m}, 32'hA);
        chk("ovr_hold_lsb", {28'd0, p_out_l}, 32'h5);
        chk("ovr_pvalid", {31'd0, pv_m}, 32'd1);
        send_frame(4'h5, 1'b0, 0, 1'b0, 1'b1);
        chk("ovr_set_wins", {31'd0, ovr_m}, 32'd1);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        chk("ovr_clr", {31'd0, ovr_m | ovr_l}, 32'd0);
        send_frame(4'h3, 1'b1, 0, 1'b1, 1'b0);
        chk("drain_load_pout", {28'd0, p_out_m}, 32'h3);
        chk("drain_load_pvalid", {31'd0, pv_m}, 32'd1);
        chk("drain_load_ovr", {31'd0, ovr_m | ovr_l}, 32'd0);
        step();

        // Resync: s_start on the 3rd bit restarts the frame.
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b0);
        q_m.push_back(4'hF);
        q_l.push_back(4'hF);
        drive_bit(1'b1, 1'b1);
        chk("resync_ferr", {31'd0, fe_m & fe_l}, 32'd1);
        drive_bit(1'b1, 1'b0);
        chk("resync_ferr_end", {31'd0, fe_m | fe_l}, 32'd0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        chk("resync_pout", {28'd0, p_out_m}, 32'hF);
        chk("resync_fe_cnt", fe_cnt_m + fe_cnt_l, 32'd2);
        step();

        // Reset during a partial word.
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_pout", {28'd0, p_out_m | p_out_l}, 32'd0);
        chk("mid_rst_flags", {29'd0, pv_m | pv_l, ovr_m | ovr_l, fe_m | fe_l}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        send_frame(4'h9, 1'b1, 0, 1'b0, 1'b0);
        chk("post_rst_msb", {28'd0, p_out_m}, 32'h9);
        chk("post_rst_lsb", {28'd0, p_out_l}, 32'h9);
        step(); step();
        chk("post_rst_fe_cnt", fe_cnt_m + fe_cnt_l, 32'd2);
        chk("sb_msb_drained", q_m.size(), 32'd0);
        chk("sb_lsb_drained", q_l.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
